// File: rtl/sp1_sp_ram_if.sv
// Bus bundle for the sp1_sp_ram single-port RAM.
// master: drives the access request and receives dout.
// slave: the RAM side.
interface sp1_sp_ram_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  logic          cs;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;

  modport master (output cs, output we, output adr, output din, input dout);
  modport slave  (input cs, input we, input adr, input din, output dout);
endinterface

// File: rtl/sp1_sp_ram.sv
// sp1_sp_ram: single-port synchronous RAM with chip select, write enable
// and a registered read port. The array is not reset; only dout is.
// Addresses at or above DS are discarded on write and read back as zero.
// Optional macro SP1_RAM_WRFWD_EN: a write also loads dout with din
// (zero for out-of-range writes). Without it, dout holds across writes.
module sp1_sp_ram #(
  parameter int AW = 6,
  parameter int DW = 32,
  parameter int DS = 64
) (
  input logic          clk,
  input logic          rst,
  sp1_sp_ram_if.slave  bus
);

  // DS may equal 2^AW, so the bound needs one extra bit.
  localparam logic [AW:0] DEPTH = (AW+1)'(DS);

  logic [DW-1:0] mem_q [0:DS-1];
  logic [DW-1:0] dout_q, dout_d;
  logic          in_range;
  logic          wr_en;

  // Access decode; rst at the edge suppresses the write.
  always_comb begin
    in_range = ({1'b0, bus.adr} < DEPTH);
    wr_en    = bus.cs && bus.we && in_range && !rst;
  end

  // Next value of the read register; cs gates everything so X on the
  // other inputs during idle cycles cannot leak into dout.
  always_comb begin
    dout_d = dout_q;
    if (bus.cs) begin
      if (bus.we) begin
`ifdef SP1_RAM_WRFWD_EN
        dout_d = in_range ? bus.din : '0;
`endif
      end else begin
        dout_d = in_range ? mem_q[bus.adr] : '0;
      end
    end
  end

  // Storage array write port (no reset: contents survive rst).
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[bus.adr] <= bus.din;
  end

  // Read data register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_q <= '0;
    else     dout_q <= dout_d;
  end

  assign bus.dout = dout_q;

endmodule

// File: tb/tb_sp1_sp_ram.sv
// Self-checking bench for sp1_sp_ram. Two instances share one stimulus:
// dut1 with full depth (DS=64) and dut2 with DS=40 to exercise the
// out-of-range address behaviour.
module tb_sp1_sp_ram;

  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int DS2 = 40;

  typedef struct {
    string         tag;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } exp_t;

  logic clk;
  logic rst;

  sp1_sp_ram_if #(.AW(AW), .DW(DW)) bus  ();
  sp1_sp_ram_if #(.AW(AW), .DW(DW)) bus2 ();

  assign bus2.cs  = bus.cs;
  assign bus2.we  = bus.we;
  assign bus2.adr = bus.adr;
  assign bus2.din = bus.din;

  sp1_sp_ram #(.AW(AW), .DW(DW), .DS(64))  dut1 (.clk(clk), .rst(rst), .bus(bus));
  sp1_sp_ram #(.AW(AW), .DW(DW), .DS(DS2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   checks = 0;
  int unsigned   passed = 0;
  exp_t          sb_q[$];
  logic [DW-1:0] model [0:63];
  logic [DW-1:0] hold1 = '0;
  logic [DW-1:0] hold2 = '0;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = sb_q.pop_front();
    check({e.tag, "_dut1"}, bus.dout,  e.e1);
    check({e.tag, "_dut2"}, bus2.dout, e.e2);
  endtask

  // One clocked access; expected dout values are pushed before the edge
  // and compared 1 time unit after it.
  task automatic access(input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input string tag);
    exp_t e;
    if (w) begin
      model[a] = d;
`ifdef SP1_RAM_WRFWD_EN
      hold1 = d;
      hold2 = (a < DS2) ? d : '0;
`endif
    end else begin
      hold1 = model[a];
      hold2 = (a < DS2) ? model[a] : '0;
    end
    e.tag = tag; e.e1 = hold1; e.e2 = hold2;
    sb_q.push_back(e);
    bus.cs = 1'b1; bus.we = w; bus.adr = a; bus.din = d;
    @(posedge clk); #1;
    pop_check();
  endtask

  task automatic idle(input int unsigned n, input string tag);
    exp_t e;
    for (int unsigned i = 0; i < n; i++) begin
      e.tag = tag; e.e1 = hold1; e.e2 = hold2;
      sb_q.push_back(e);
      bus.cs = 1'b0; bus.we = 1'bx; bus.adr = 'x; bus.din = 'x;
      @(posedge clk); #1;
      pop_check();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cs = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.din = '0;
    #1;
    check("rst_async_dut1", bus.dout,  '0);
    check("rst_async_dut2", bus2.dout, '0);
    for (int unsigned i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst_hold_dut1", bus.dout,  '0);
      check("rst_hold_dut2", bus2.dout, '0);
    end
    rst = 1'b0;
    idle(1, "post_rst");

    access(1'b1, 6'h05, 32'h12345678, "wr05");
    access(1'b0, 6'h05, '0,           "rd05");
    idle(3, "idle_x_hold");
    access(1'b0, 6'h05, '0,           "rd05_after_x");

    access(1'b1, 6'h00, 32'hAAAAAAAA, "wr00");
    access(1'b1, 6'h3F, 32'h55555555, "wr3f");
    access(1'b0, 6'h3F, '0,           "rd3f");
    access(1'b0, 6'h00, '0,           "rd00");

    access(1'b1, 6'h10, 32'h00000001, "wr10_a");
    access(1'b1, 6'h10, 32'h00000002, "wr10_b");
    access(1'b0, 6'h10, '0,           "rd10");

    access(1'b1, 6'h27, 32'hC0FFEE27, "wr27_last");
    access(1'b1, 6'h28, 32'hC0FFEE28, "wr28_oob");
    access(1'b0, 6'h27, '0,           "rd27_last");
    access(1'b0, 6'h28, '0,           "rd28_oob");

    access(1'b0, 6'h05, '0,           "rd05_b");
    access(1'b1, 6'h06, 32'hDEADBEEF, "wr06_dout");
    access(1'b0, 6'h06, '0,           "rd06");

    // Async pulse between edges after dout shows 0x12345678.
    access(1'b0, 6'h05, '0,           "rd05_pre_rst");
    bus.cs = 1'b0;
    rst = 1'b1;
    #2;
    check("rst_pulse_dut1", bus.dout,  '0);
    check("rst_pulse_dut2", bus2.dout, '0);
    rst = 1'b0;
    hold1 = '0; hold2 = '0;
    idle(1, "rst_pulse_hold");

    // Write coinciding with asserted rst must be ignored.
    rst = 1'b1;
    bus.cs = 1'b1; bus.we = 1'b1; bus.adr = 6'h05; bus.din = 32'hFFFFFFFF;
    @(posedge clk); #1;
    check("rst_wr_dut1", bus.dout,  '0);
    check("rst_wr_dut2", bus2.dout, '0);
    rst = 1'b0;
    access(1'b0, 6'h05, '0,           "rd05_post_rst");
    idle(1, "final_hold");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
